// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous-read 32-bit word memory between the instruction-fetch
// port (read-only) and the load/store data port. A winner is chosen in IDLE or
// RESP, its command is registered, the memory is driven for one ACCESS cycle,
// and the response (read data or write acknowledge) is returned in RESP.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : on simultaneous requests the port not granted most recently wins
//   undefined : fixed priority, data port over instruction port
//
// Address handling: word address = addr[ADDR_WIDTH+1:2]; the byte offset and
// the bits above the memory size are ignored, so addresses alias.
// The byte-offset and upper address bits are deliberately left unused.

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  // instruction-fetch port
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [31:0]           i_rdata,
  // load/store data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_wmask,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  // memory side
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_id_d;       // 1 = data port owns the current access
  logic                  r_we;         // current access is a write
  logic [ADDR_WIDTH-1:0] r_addr;       // captured word address
  logic [3:0]            r_mem_wmask;  // captured byte mask, only nonzero in ACCESS
  logic [31:0]           r_mem_wdata;  // captured store data
  logic                  r_mem_en;
  logic                  r_i_rvalid;
  logic                  r_d_rvalid;
  logic                  r_busy;
  logic [31:0]           r_i_rdata;
  logic [31:0]           r_d_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                  r_last_i;     // 1 = instruction port was granted most recently
`endif

  logic                  w_open;
  logic                  w_i_gnt;
  logic                  w_d_gnt;
  logic                  w_any_gnt;
  logic [ADDR_WIDTH-1:0] w_i_word;
  logic [ADDR_WIDTH-1:0] w_d_word;
  logic [31:0]           w_i_rdata;
  logic [31:0]           w_d_rdata;
  logic                  w_unused_addr_bits;

  assign w_i_word  = i_addr[ADDR_WIDTH+1:2];
  assign w_d_word  = d_addr[ADDR_WIDTH+1:2];
  assign w_any_gnt = w_i_gnt | w_d_gnt;
  assign w_unused_addr_bits = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0],
                                d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

  // Arbitration window: open in IDLE and RESP, closed while resetn is low.
  always_comb begin
    w_open = 1'b0;
    if (!resetn) begin
      w_open = 1'b0;
    end else if ((r_state == ST_IDLE) || (r_state == ST_RESP)) begin
      w_open = 1'b1;
    end else begin
      w_open = 1'b0;
    end
  end

  // Grant selection; at most one grant per cycle.
  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!w_open) begin
      w_i_gnt = 1'b0;
      w_d_gnt = 1'b0;
    end else if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (r_last_i) begin
        w_d_gnt = 1'b1;
      end else begin
        w_i_gnt = 1'b1;
      end
`else
      w_d_gnt = 1'b1;
`endif
    end else if (d_req) begin
      w_d_gnt = 1'b1;
    end else if (i_req) begin
      w_i_gnt = 1'b1;
    end else begin
      w_i_gnt = 1'b0;
      w_d_gnt = 1'b0;
    end
  end

  // Read data is forwarded from the memory during RESP, otherwise the held copy.
  always_comb begin
    w_i_rdata = r_i_rdata;
    w_d_rdata = r_d_rdata;
    if ((r_state == ST_RESP) && !r_we) begin
      if (r_id_d) begin
        w_d_rdata = mem_rdata;
      end else begin
        w_i_rdata = mem_rdata;
      end
    end else begin
      w_i_rdata = r_i_rdata;
      w_d_rdata = r_d_rdata;
    end
  end

  // Main FSM: state, command capture, registered memory strobes and responses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_id_d      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_mem_wmask <= 4'b0000;
      r_mem_wdata <= 32'h0000_0000;
      r_mem_en    <= 1'b0;
      r_i_rvalid  <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_busy      <= 1'b0;
      r_i_rdata   <= 32'h0000_0000;
      r_d_rdata   <= 32'h0000_0000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_i    <= 1'b1;
`endif
    end else begin
      // The read word is kept only at the end of the RESP cycle that produced it.
      if ((r_state == ST_RESP) && !r_we) begin
        if (r_id_d) begin
          r_d_rdata <= mem_rdata;
        end else begin
          r_i_rdata <= mem_rdata;
        end
      end else begin
        r_i_rdata <= r_i_rdata;
        r_d_rdata <= r_d_rdata;
      end

      case (r_state)
        ST_IDLE, ST_RESP: begin
          r_i_rvalid <= 1'b0;
          r_d_rvalid <= 1'b0;
          if (w_any_gnt) begin
            r_state     <= ST_ACCESS;
            r_id_d      <= w_d_gnt;
            r_we        <= w_d_gnt ? d_we : 1'b0;
            r_addr      <= w_d_gnt ? w_d_word : w_i_word;
            r_mem_wmask <= (w_d_gnt && d_we) ? d_wmask : 4'b0000;
            r_mem_wdata <= w_d_gnt ? d_wdata : 32'h0000_0000;
            r_mem_en    <= 1'b1;
            r_busy      <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_i    <= w_i_gnt;
`endif
          end else begin
            r_state     <= ST_IDLE;
            r_mem_en    <= 1'b0;
            r_mem_wmask <= 4'b0000;
            r_busy      <= 1'b0;
          end
        end
        ST_ACCESS: begin
          r_state     <= ST_RESP;
          r_mem_en    <= 1'b0;
          r_mem_wmask <= 4'b0000;
          r_i_rvalid  <= ~r_id_d;
          r_d_rvalid  <= r_id_d;
          r_busy      <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mem_en    <= 1'b0;
          r_mem_wmask <= 4'b0000;
          r_i_rvalid  <= 1'b0;
          r_d_rvalid  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign i_gnt     = w_i_gnt;
  assign d_gnt     = w_d_gnt;
  assign i_rvalid  = r_i_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign i_rdata   = w_i_rdata;
  assign d_rdata   = w_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_addr  = r_addr;
  assign mem_wmask = r_mem_wmask;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed test-plan scenarios followed by
// randomized traffic from two independent port drivers. A monitor predicts
// grants from the arbitration rules, pushes each accepted command into
// scoreboard queues and checks the memory strobe and the response as the DUT
// presents them. Expected read data comes from a reference memory updated in
// grant order.

module tb_mem_port_arbiter;

  localparam int AW    = 8;
  localparam int WORDS = 256;

  logic          clk;
  logic          resetn;
  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_wmask;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;

  mem_port_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int k);
    if (k == 3) return 32'h0010_0093;
    if (k == 4) return 32'h1122_3344;
    return 32'h5A00_0000 | (32'(k) * 32'h0001_0101);
  endfunction

  // ---------------- memory array seen by the DUT ----------------
  logic [31:0] mem [WORDS];
  logic        load_mem;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int k = 0; k < WORDS; k++) mem[k] <= init_word(k);
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit          id_d;
    bit          we;
    logic [3:0]  wmask;
    logic [7:0]  word;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gcyc;
  } acc_t;

  logic [31:0] ref_mem [WORDS];
  acc_t        mem_q[$];
  acc_t        resp_q[$];
  bit          gnt_log[$];     // 1 = data port
  int          gnt_cyc_log[$];
  bit          mon_on = 1'b0;
  int          cyc = 0;
  bit          b1 = 1'b0;      // an access was accepted last cycle (memory cycle now)
  bit          b2 = 1'b0;      // an access hit the memory last cycle (response now)
  bit          m_last_was_i = 1'b1;
  logic [31:0] m_last_i = 32'h0;
  logic [31:0] m_last_d = 32'h0;
  logic [7:0]  last_mem_addr = 8'h0;

  always @(negedge clk) begin
    bit   exp_ig, exp_dg, have_r;
    acc_t a, r;
    cyc++;
    if (mon_on) begin
      exp_ig = 1'b0; exp_dg = 1'b0; have_r = 1'b0;
      if (resetn && !b1) begin
        if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          exp_dg = m_last_was_i;
          exp_ig = !m_last_was_i;
`else
          exp_dg = 1'b1;
`endif
        end else begin
          exp_ig = i_req;
          exp_dg = d_req;
        end
      end
      if (i_req || d_req || i_gnt || d_gnt)
        chk("grant", {30'h0, i_gnt, d_gnt}, {30'h0, exp_ig, exp_dg});
      chk("busy", {31'h0, busy}, {31'h0, b1 | b2});

      // memory strobe of the access accepted last cycle
      chk("mem_en", {31'h0, mem_en}, {31'h0, b1});
      if (b1 && mem_q.size() > 0) begin
        a = mem_q.pop_front();
        chk("mem_addr", {24'h0, mem_addr}, {24'h0, a.word});
        chk("mem_wmask", {28'h0, mem_wmask}, {28'h0, a.we ? a.wmask : 4'b0000});
        if (a.we) chk("mem_wdata", mem_wdata, a.wdata);
      end
      if (mem_en) last_mem_addr = mem_addr;

      // response of the access that used the memory last cycle
      if (b2 && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        have_r = 1'b1;
        chk("resp_latency", 32'(cyc - r.gcyc), 32'd2);
      end
      chk("i_rvalid", {31'h0, i_rvalid}, {31'h0, have_r && !r.id_d});
      chk("d_rvalid", {31'h0, d_rvalid}, {31'h0, have_r && r.id_d});
      if (have_r && !r.id_d) begin
        chk("i_rdata", i_rdata, r.rdata);
        m_last_i = r.rdata;
      end else begin
        chk("i_rdata_hold", i_rdata, m_last_i);
      end
      if (have_r && r.id_d && !r.we) begin
        chk("d_rdata", d_rdata, r.rdata);
        m_last_d = r.rdata;
      end else begin
        chk("d_rdata_hold", d_rdata, m_last_d);
      end

      // accept the predicted winner into the scoreboard
      if (exp_ig || exp_dg) begin
        a.id_d  = exp_dg;
        a.we    = exp_dg ? d_we : 1'b0;
        a.wmask = d_wmask;
        a.word  = exp_dg ? d_addr[9:2] : i_addr[9:2];
        a.wdata = d_wdata;
        a.gcyc  = cyc;
        a.rdata = ref_mem[a.word];
        if (a.we)
          for (int b = 0; b < 4; b++)
            if (a.wmask[b]) ref_mem[a.word][8*b +: 8] = a.wdata[8*b +: 8];
        mem_q.push_back(a);
        resp_q.push_back(a);
        gnt_log.push_back(exp_dg);
        gnt_cyc_log.push_back(cyc);
        m_last_was_i = exp_ig;
      end

      // reset drops the access currently in its memory cycle and clears outputs
      if (!resetn) begin
        if (resp_q.size() > 0 && resp_q[$].gcyc == cyc - 1) void'(resp_q.pop_back());
        m_last_i = 32'h0;
        m_last_d = 32'h0;
        m_last_was_i = 1'b1;
        b2 = 1'b0;
        b1 = 1'b0;
      end else begin
        b2 = b1;
        b1 = exp_ig || exp_dg;
      end
    end
  end

  // ---------------- port drivers (called at posedge+1) ----------------
  task automatic do_i(input logic [31:0] addr);
    int n = 0;
    i_req = 1'b1; i_addr = addr;
    forever begin
      @(negedge clk);
      if (i_gnt) break;
      n++;
      if (n > 60) begin
        errors++; checks++;
        $display("FAIL i_gnt_timeout actual=0 required=1");
        break;
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic do_d(input logic we, input logic [3:0] mask,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    d_req = 1'b1; d_we = we; d_wmask = mask; d_addr = addr; d_wdata = wdata;
    forever begin
      @(negedge clk);
      if (d_gnt) break;
      n++;
      if (n > 60) begin
        errors++; checks++;
        $display("FAIL d_gnt_timeout actual=0 required=1");
        break;
      end
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy && resp_q.size() == 0 && !i_req && !d_req) break;
      n++;
      if (n > 200) begin
        errors++; checks++;
        $display("FAIL idle_timeout actual=busy required=idle");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr();
    return ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit exp_seq [4];
    resetn = 1'b0; load_mem = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_wmask = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    for (int k = 0; k < WORDS; k++) ref_mem[k] = init_word(k);
    @(posedge clk); #1;
    mon_on = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b1; load_mem = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_mem_en", {31'h0, mem_en}, 32'h0);
    chk("reset_i_rdata", i_rdata, 32'h0);
    chk("reset_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1;

    // single fetch of word 3
    do_i(32'h0000_000C);
    wait_idle();
    chk("fetch_word3", i_rdata, 32'h0010_0093);

    // byte store into word 4 followed by a load
    do_d(1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AB00);
    do_d(1'b0, 4'b0000, 32'h0000_0010, 32'h0);
    wait_idle();
    chk("store_load", d_rdata, 32'h1122_AB44);

    // contention from reset: two requests per port, held back to back
    reset_pulse();
    gnt_log.delete(); gnt_cyc_log.delete();
    fork
      begin do_d(1'b0, 4'h0, 32'h0000_0014, 32'h0); do_d(1'b0, 4'h0, 32'h0000_0018, 32'h0); end
      begin do_i(32'h0000_000C); do_i(32'h0000_000C); end
    join
    wait_idle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
    chk("contend_count", 32'(gnt_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < gnt_log.size(); k++)
      chk($sformatf("contend_order%0d", k), {31'h0, gnt_log[k]}, {31'h0, exp_seq[k]});
    if (gnt_cyc_log.size() >= 2)
      chk("contend_spacing", 32'(gnt_cyc_log[1] - gnt_cyc_log[0]), 32'd2);

    // aliasing: 0x404 maps onto word 1
    do_d(1'b0, 4'h0, 32'h0000_0404, 32'h0);
    wait_idle();
    chk("alias_mem_addr", {24'h0, last_mem_addr}, 32'd1);
    chk("alias_data", d_rdata, init_word(1));

    // reset asserted during the memory cycle of a fetch
    i_req = 1'b1; i_addr = 32'h0000_0008;
    begin
      int n = 0;
      forever begin
        @(negedge clk);
        if (i_gnt || n > 60) break;
        n++;
      end
      chk("mid_reset_gnt", {31'h0, i_gnt}, 32'h1);
    end
    @(posedge clk); #1;
    i_req = 1'b0; resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("mid_reset_mem_en", {31'h0, mem_en}, 32'h0);
    chk("mid_reset_busy", {31'h0, busy}, 32'h0);
    chk("mid_reset_i_rdata", i_rdata, 32'h0);
    chk("mid_reset_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1;
    do_i(32'h0000_000C);
    wait_idle();
    chk("after_reset_fetch", i_rdata, 32'h0010_0093);

    // zero-mask write: acknowledged, memory untouched
    do_d(1'b1, 4'b0000, 32'h0000_0014, 32'hDEAD_BEEF);
    wait_idle();
    chk("zero_mask_mem", mem[5], init_word(5));

    // randomized traffic from both ports
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_i(rnd_addr());
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_d(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rnd_addr(), $urandom());
        end
      end
    join
    wait_idle();
    chk("drain", 32'(resp_q.size() + mem_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single synchronous-read word memory between the CPU's instruction-fetch port and its load/store data port. It arbitrates between the two requesters and registers the winning command. It drives the memory for one cycle and returns read data or a write acknowledge to the winner. It sits between the multi-cycle RV32I core and the 32-bit memory array, and replaces the core's direct `MEM[PC[31:2]]` access.

## Interface
- `ADDR_WIDTH`, default 8: word-address bits; memory holds 2^ADDR_WIDTH 32-bit words.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `i_req`  in  1  instruction-fetch request; must be held until `i_gnt`.
- `i_addr`  in  32  instruction byte address.
- `i_gnt`  out  1  combinational; request accepted this cycle.
- `i_rvalid`  out  1  one-cycle pulse; `i_rdata` valid.
- `i_rdata`  out  32  fetched word; holds its value until the next instruction read.
- `d_req`  in  1  data request; must be held until `d_gnt`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_wmask`  in  4  byte-lane write enables; bit n selects `d_wdata[8n+7:8n]`.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  combinational; request accepted this cycle.
- `d_rvalid`  out  1  one-cycle pulse; read data valid, or write completed.
- `d_rdata`  out  32  loaded word; holds its value until the next data read.
- `mem_en`  out  1  memory access strobe.
- `mem_addr`  out  ADDR_WIDTH  word address.
- `mem_wmask`  out  4  byte write enables; all zero on reads.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  read data, valid one cycle after `mem_en`.
- `busy`  out  1  high in ACCESS or RESP.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- Arbitration is open in IDLE and in RESP. If any request is pending, the FSM assigns the grant, moves to ACCESS, and captures the winner's id, word address, we, wmask and wdata into registers.
- If no request is pending in IDLE, the FSM stays in IDLE. If no request is pending in RESP, it returns to IDLE.
- ACCESS:
  - `mem_en`=1 and `mem_addr` = captured word address.
  - `mem_wmask` = captured mask if we=1, else 0.
  - `mem_wdata` = captured data.
  - Always moves to RESP.
- RESP:
  - The winner's `*_rvalid` is 1.
  - On a read, `mem_rdata` is latched into the winner's `*_rdata` register.
  - On a write, only `d_rvalid` is raised; `d_rdata` is unchanged.
- The instruction port is read-only.
- A write with `d_wmask`=0 performs no memory write but is still acknowledged with `d_rvalid`.
- Word address = `addr[ADDR_WIDTH+1:2]`. Bits [1:0] are ignored (no misalignment trap). Bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo 4·2^ADDR_WIDTH.
- `i_gnt` and `d_gnt` are never both 1 and are only asserted in IDLE or RESP. A requester must drop or change its request after seeing its grant; otherwise it is granted again.
- Default priority: when both ports request in the same cycle, the data port wins.
- Reset, or reset asserted mid-operation:
  - State goes to IDLE and the in-flight access is dropped (no `rvalid`, no memory write if ACCESS has not been reached).
  - All outputs go to 0: `i_rdata`, `d_rdata`, `*_rvalid`, `mem_en`, `mem_wmask`, `busy`.
  - The round-robin pointer resets to "instruction last".

## Timing
- Request accepted in cycle N (`gnt`=1) → `mem_en` in N+1 → `rvalid` in N+2, with `rdata` valid from N+2 until overwritten.
- Throughput is one access per 2 cycles. A new grant may coincide with the `rvalid` of the previous access.
- Back-to-back stream: grants occur in cycles N, N+2, N+4, and so on.
- `gnt` depends combinationally on `req`, state and the priority pointer. `rvalid`, `busy` and the `mem_*` outputs are decoded from registered state and carry no combinational path from the request inputs.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - Defined: on simultaneous requests, the port not granted most recently wins. The pointer updates on every grant.
  - Undefined: fixed priority, data > instruction. The pointer logic is compiled out.

## Test plan
- Single fetch, memory word 3 = 0x00100093: `i_req`, `i_addr`=0x0C → `i_gnt` in cycle 0, `mem_en`/`mem_addr`=3 in cycle 1, `i_rvalid`=1 with `i_rdata`=0x00100093 in cycle 2; `d_rvalid` stays 0.
- Byte store then load:
  - Store: `d_we`=1, `d_wmask`=4'b0010, `d_addr`=0x10, `d_wdata`=0x0000AB00 over a word holding 0x11223344 → `d_rvalid` in cycle 2.
  - Subsequent read of 0x10 → `d_rdata`=0x1122AB44.
- Contention: `i_req` and `d_req` both held from cycle 0.
  - Without the macro: data granted cycle 0, instruction granted cycle 2.
  - With the macro, 4 sequential contended accesses → grants alternate D, I, D, I.
- Aliasing with `ADDR_WIDTH`=8: read at 0x00000404 → `mem_addr`=1 (same as 0x04).
- Reset mid-access: `resetn`=0 in the ACCESS cycle → next cycle `mem_en`=0, `busy`=0, no `rvalid` pulse, both `rdata`=0, FSM in IDLE; a new request after release completes normally.
- Zero-mask write, `d_we`=1 with `d_wmask`=0 → `mem_wmask`=0 in ACCESS, memory unchanged, `d_rvalid` pulses in cycle 2.
